// File: rtl/pll_lock_ctrl.sv
// PLL power-up sequencer: pulses the PLL reset, waits for a qualified lock with a timeout and
// bounded retries, then releases the core reset; re-sequences on loss of lock or on restart.
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lol_cnt
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [7:0]    LOL_MAX   = 8'hFF;

  typedef enum logic [2:0] {
    S_PRST = 3'd0,
    S_WAIT = 3'd1,
    S_STAB = 3'd2,
    S_RUN  = 3'd3,
    S_FAIL = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            locked_s;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [SW-1:0]   stab_cnt_q, stab_cnt_d;
  logic            pll_rst_q, pll_rst_d;
  logic            sys_rst_q, sys_rst_d;
  logic            ready_q, ready_d;
  logic            fail_q, fail_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      lol_q, lol_d;

  logic            timeout_c;
  logic            lol_evt_c;
  logic            to_hit_c;
  logic [3:0]      retry_inc_c;
  logic            in_lock_wait_c;

  assign locked_s = sync_q[1];

  // State, synchroniser, counters and registered outputs
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_PRST;
      sync_q     <= '0;
      rst_cnt_q  <= '0;
      to_cnt_q   <= '0;
      stab_cnt_q <= '0;
      pll_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
      retry_q    <= '0;
      lol_q      <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], pll_locked};
      rst_cnt_q  <= rst_cnt_d;
      to_cnt_q   <= to_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      pll_rst_q  <= pll_rst_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
      retry_q    <= retry_d;
      lol_q      <= lol_d;
    end
  end

  // Next state; restart outranks timeout, which outranks lock transitions
  always_comb begin
    state_d     = state_q;
    timeout_c   = 1'b0;
    lol_evt_c   = 1'b0;
    to_hit_c    = (to_cnt_q == TO_LAST);
    retry_inc_c = retry_q + 4'd1;
    if (restart) begin
      state_d = S_PRST;
    end else begin
      case (state_q)
        S_PRST: if (rst_cnt_q == RST_LAST) state_d = S_WAIT;
        S_WAIT: begin
          if (to_hit_c) begin
            timeout_c = 1'b1;
            state_d   = (retry_inc_c == RETRY_MAX) ? S_FAIL : S_PRST;
          end else if (locked_s) begin
            state_d = (LOCK_STABLE == 1) ? S_RUN : S_STAB;
          end
        end
        S_STAB: begin
          if (to_hit_c) begin
            timeout_c = 1'b1;
            state_d   = (retry_inc_c == RETRY_MAX) ? S_FAIL : S_PRST;
          end else if (!locked_s) begin
            state_d = S_WAIT;
          end else if (stab_cnt_q == STAB_LAST) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            lol_evt_c = 1'b1;
            state_d   = S_PRST;
          end
        end
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_PRST;
      endcase
    end
  end

  // Counter and output next values, all derived from the chosen next state
  always_comb begin
    rst_cnt_d      = '0;
    to_cnt_d       = '0;
    stab_cnt_d     = '0;
    retry_d        = retry_q;
    lol_d          = lol_q;
    in_lock_wait_c = (state_q == S_WAIT) || (state_q == S_STAB);

    if (state_d == S_PRST && state_q == S_PRST && !restart && rst_cnt_q != RST_LAST)
      rst_cnt_d = rst_cnt_q + RW'(1);

    // Timeout counter spans WAIT and STAB together, so a lock glitch does not reset it
    if ((state_d == S_WAIT || state_d == S_STAB) && in_lock_wait_c && to_cnt_q != TO_LAST)
      to_cnt_d = to_cnt_q + TW'(1);

    if (state_d == S_STAB)
      stab_cnt_d = (state_q == S_STAB && stab_cnt_q != STAB_LAST) ? stab_cnt_q + SW'(1) : SW'(1);

    if (restart) begin
      retry_d = '0;
    end else if (timeout_c) begin
      retry_d = retry_inc_c;
    end else if (lol_evt_c) begin
      retry_d = '0;
      if (lol_q != LOL_MAX) lol_d = lol_q + 8'd1;
    end

    pll_rst_d = (state_d == S_PRST) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign lol_cnt   = lol_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: a vector table walks lock, glitch, timeout, FAIL and restart,
// then hand-written sequences cover lol_cnt saturation and asynchronous reset.
module tb_pll_lock_ctrl;

  localparam int unsigned RST_CYCLES   = 4;
  localparam int unsigned LOCK_TIMEOUT = 100;
  localparam int unsigned LOCK_STABLE  = 8;
  localparam int unsigned MAX_RETRY    = 3;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] lol_cnt;

  always #5 refclk = ~refclk;

  pll_lock_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .restart   (restart),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .lol_cnt   (lol_cnt)
  );

  typedef struct {
    logic        restart;
    logic        locked;
    int          ticks;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [15:0] pk(input logic pr, input logic sr, input logic rd,
                                     input logic fl, input logic [3:0] rt, input logic [7:0] lc);
    return {pr, sr, rd, fl, rt, lc};
  endfunction

  task automatic add(input logic r, input logic l, input int t, input logic pr, input logic sr,
                     input logic rd, input logic fl, input logic [3:0] rt, input logic [7:0] lc);
    vec_t v;
    v.restart = r;
    v.locked  = l;
    v.ticks   = t;
    v.exp     = pk(pr, sr, rd, fl, rt, lc);
    vecs.push_back(v);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {pll_rst, sys_rst, ready, fail, retry_cnt, lol_cnt};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got pll_rst/sys_rst/ready/fail=%b retry=%0d lol=%0d, required %b retry=%0d lol=%0d",
               name, act[15:12], act[11:8], act[7:0], exp[15:12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic wait_ready(input logic val, input int maxc, input string name);
    int c;
    c = 0;
    while (ready !== val && c < maxc) begin
      tick(1);
      c++;
    end
    n_vec++;
    if (ready !== val) begin
      n_err++;
      $display("FAIL %s: ready=%b after %0d cycles, required %b", name, ready, maxc, val);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lol_exp;
    // restart, locked, ticks, pll_rst, sys_rst, ready, fail, retry, lol
    add(0, 0, 0,   1, 1, 0, 0, 0, 0);  // just released
    add(0, 0, 3,   1, 1, 0, 0, 0, 0);  // pll_rst still high
    add(0, 0, 1,   0, 1, 0, 0, 0, 0);  // 4 cycles -> WAIT
    add(0, 1, 9,   0, 1, 0, 0, 0, 0);  // lock rises, not yet qualified
    add(0, 1, 1,   0, 0, 1, 0, 0, 0);  // RUN 10 cycles after rise
    add(0, 0, 2,   0, 0, 1, 0, 0, 0);  // loss still in synchroniser
    add(0, 0, 1,   1, 1, 0, 0, 0, 1);  // loss seen: PRST, lol=1
    add(0, 0, 3,   1, 1, 0, 0, 0, 1);
    add(0, 0, 1,   0, 1, 0, 0, 0, 1);  // 4-cycle pll_rst pulse
    add(0, 1, 5,   0, 1, 0, 0, 0, 1);  // glitch: high 5
    add(0, 0, 3,   0, 1, 0, 0, 0, 1);  // low 3
    add(0, 1, 9,   0, 1, 0, 0, 0, 1);  // high again
    add(0, 1, 1,   0, 0, 1, 0, 0, 1);  // RUN 10 after final rise
    add(0, 0, 3,   1, 1, 0, 0, 0, 2);  // second loss
    add(0, 0, 4,   0, 1, 0, 0, 0, 2);  // WAIT, lock held low
    add(0, 0, 99,  0, 1, 0, 0, 0, 2);  // one cycle before timeout
    add(0, 0, 1,   1, 1, 0, 0, 1, 2);  // timeout 1
    add(0, 0, 4,   0, 1, 0, 0, 1, 2);
    add(0, 0, 100, 1, 1, 0, 0, 2, 2);  // timeout 2
    add(0, 0, 104, 1, 1, 0, 1, 3, 2);  // timeout 3 -> FAIL
    add(0, 0, 20,  1, 1, 0, 1, 3, 2);  // FAIL holds
    add(1, 0, 1,   1, 1, 0, 0, 0, 2);  // restart in FAIL
    add(0, 0, 3,   1, 1, 0, 0, 0, 2);
    add(0, 0, 1,   0, 1, 0, 0, 0, 2);
    add(0, 0, 104, 0, 1, 0, 0, 1, 2);  // one timeout, back in WAIT
    add(1, 0, 1,   1, 1, 0, 0, 0, 2);  // restart in WAIT
    add(1, 0, 5,   1, 1, 0, 0, 0, 2);  // level restart holds PRST
    add(0, 0, 3,   1, 1, 0, 0, 0, 2);
    add(0, 0, 1,   0, 1, 0, 0, 0, 2);
    add(0, 1, 10,  0, 0, 1, 0, 0, 2);  // lock to RUN

    #12;
    check("in_reset", pk(1, 1, 0, 0, 4'd0, 8'd0));
    @(negedge refclk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      restart    = vecs[i].restart;
      pll_locked = vecs[i].locked;
      tick(vecs[i].ticks);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // lol_cnt saturation across 256 further losses
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b0;
      wait_ready(1'b0, 5, "lol_drop");
      lol_exp = (3 + i > 255) ? 255 : 3 + i;
      check($sformatf("lol_sat%0d", i), pk(1, 1, 0, 0, 4'd0, 8'(lol_exp)));
      pll_locked = 1'b1;
      wait_ready(1'b1, 30, "lol_relock");
    end

    // asynchronous reset between clock edges while in RUN
    @(posedge refclk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", pk(1, 1, 0, 0, 4'd0, 8'd0));
    tick(1);
    check("rst_held", pk(1, 1, 0, 0, 4'd0, 8'd0));
    @(negedge refclk);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_prst", pk(1, 1, 0, 0, 4'd0, 8'd0));
    tick(1);
    check("post_rst_wait", pk(0, 1, 0, 0, 4'd0, 8'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
